// File: rtl/knight_uart_pkg.sv
// Shared types and defaults for the knight remote-command UART link.
package knight_uart_pkg;

  typedef enum logic {HI, LO} asm_state_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int         DFLT_BAUD_DIV = 2604;
  localparam logic [7:0] POS_ACK       = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop sync, mid-bit sampling, byte_vld/frm_err decided at the stop sample.
// Latency: byte_vld is combinational in the stop-sample cycle; no backpressure, a byte not taken is lost.
module uart_rx_byte
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV = DFLT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_dat,
  output logic       byte_vld,
  output logic       frm_err,
  output logic       busy
);

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  logic          rx_s1, rx_s2, rx_prev;
  uart_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    byte_vld  = 1'b0;
    frm_err   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s2) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // A line that is high again at mid start-bit was a glitch, not a frame.
        if (cnt == HALF_END) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s2 ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s2, shift[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          state_nxt = IDLE;
          byte_vld  = rx_s2;
          frm_err   = !rx_s2;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign byte_dat = shift;

endmodule

// File: rtl/knight_cmd_uart.sv
// Remote command link: two RX bytes (hi, lo) -> 16-bit cmd; one 8-bit response serialized on TX.
// cmd_rdy one clk after the low byte's stop sample; no backpressure (overrun flags ovr_err, busy TX ignores send_resp).
module knight_cmd_uart
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV = DFLT_BAUD_DIV,
  parameter int BYTE_TMO = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err,
  output logic        ovr_err
);

  localparam int            CW      = $clog2(BAUD_DIV);
  localparam int            TMO_LIM = BYTE_TMO * BAUD_DIV;
  localparam int            TW      = $clog2(TMO_LIM + 1);
  localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_LIM - 1);

  logic [7:0] rx_dat;
  logic       rx_vld, rx_frm_err, rx_busy;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (RX),
    .byte_dat (rx_dat),
    .byte_vld (rx_vld),
    .frm_err  (rx_frm_err),
    .busy     (rx_busy)
  );

  asm_state_t    asm_state, asm_nxt;
  logic [7:0]    hi_reg;
  logic [TW-1:0] tmo_cnt;
  logic          load_hi, complete, tmo_hit;

  always_comb begin
    asm_nxt  = asm_state;
    load_hi  = 1'b0;
    complete = 1'b0;
    tmo_hit  = !rx_busy && (tmo_cnt == TMO_END);
    case (asm_state)
      HI: begin
        if (rx_vld) begin
          load_hi = 1'b1;
          asm_nxt = LO;
        end
      end
      LO: begin
        if (rx_vld) begin
          complete = 1'b1;
          asm_nxt  = HI;
        end else if (rx_frm_err || tmo_hit) begin
          asm_nxt = HI;
        end
      end
      default: asm_nxt = HI;
    endcase
  end

  // Timeout only counts idle line time; a low byte in flight is never cut off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state <= HI;
      hi_reg    <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      asm_state <= asm_nxt;
      frm_err   <= rx_frm_err;
      ovr_err   <= complete && cmd_rdy;
      if (load_hi) hi_reg <= rx_dat;
      if (load_hi)
        tmo_cnt <= '0;
      else if (asm_state == LO && !rx_busy)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (complete) cmd <= {hi_reg, rx_dat};
      if (complete)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;
    end
  end

  uart_state_t   tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]    tx_idx, tx_idx_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic          tx_nxt, sent_nxt;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    tx_nxt       = TX;
    sent_nxt     = 1'b0;
    case (tx_state)
      IDLE: begin
        if (send_resp) begin
          tx_shift_nxt = resp;
          tx_cnt_nxt   = '0;
          tx_nxt       = 1'b0;
          tx_state_nxt = START;
        end
      end
      START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nxt   = '0;
          tx_idx_nxt   = '0;
          tx_nxt       = tx_shift[0];
          tx_state_nxt = DATA;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = {1'b1, tx_shift[7:1]};
          tx_idx_nxt   = tx_idx + 3'd1;
          if (tx_idx == 3'd7) begin
            tx_nxt       = 1'b1;
            tx_state_nxt = STOP;
          end else begin
            tx_nxt = tx_shift[1];
          end
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_state_nxt = IDLE;
          sent_nxt     = 1'b1;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      TX        <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_idx    <= tx_idx_nxt;
      tx_shift  <= tx_shift_nxt;
      TX        <= tx_nxt;
      resp_sent <= sent_nxt;
    end
  end

endmodule

// File: tb/tb_knight_cmd_uart.sv
// Bench for knight_cmd_uart: table of command pairs, directed corner sequences, randomized full-duplex traffic.
module tb_knight_cmd_uart;

  localparam int B   = 16;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, frm_err, ovr_err;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int n_tests = 0;
  int n_fail  = 0;
  int frm_cnt = 0;
  int ovr_cnt = 0;
  int lat     = 0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          gap;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[4];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  knight_cmd_uart #(.BAUD_DIV(B), .BYTE_TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .frm_err     (frm_err),
    .ovr_err     (ovr_err)
  );

  always @(negedge clk) begin
    if (frm_err) frm_cnt++;
    if (ovr_err) ovr_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required finish before 80000 clks");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // All RX drive happens on negedges; each bit is held exactly B clocks.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic idle(input int bits);
    RX = 1'b1;
    repeat (bits * B) @(negedge clk);
  endtask

  task automatic rx_pair(input logic [7:0] h, input logic [7:0] l, input int gap);
    send_byte(h, 1'b1);
    idle(gap);
    send_byte(l, 1'b1);
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Receives the TX frame as a remote UART would: mid-bit samples after the start edge.
  task automatic tx_send_check(input logic [7:0] r);
    logic [7:0] got;
    logic       st, sp;
    resp      = r;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (B / 2) @(negedge clk);
    st = TX;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(negedge clk);
      got[i] = TX;
    end
    repeat (B) @(negedge clk);
    sp = TX;
    check("rand_tx_start", {31'd0, st}, 32'd0);
    check("rand_tx_data", {24'd0, got}, {24'd0, r});
    check("rand_tx_stop", {31'd0, sp}, 32'd1);
    repeat (B) @(negedge clk);
  endtask

  initial begin
    logic [9:0] fr;
    logic [9:0] bad;
    int         early, frm0;

    tbl[0] = '{8'h00, 8'hFF, 2,  16'h00FF};
    tbl[1] = '{8'hFF, 8'h00, 17, 16'hFF00};
    tbl[2] = '{8'h81, 8'h7E, 0,  16'h817E};
    tbl[3] = '{8'h5A, 8'hC3, 9,  16'h5AC3};

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    check("rst_errs", {30'd0, frm_err, ovr_err}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Basic command and latency from low-byte start edge to cmd_rdy.
    send_byte(8'h47, 1'b1);
    fork
      send_byte(8'hF3, 1'b1);
      begin
        while (cmd_rdy !== 1'b1 && lat < 12 * B) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("t1_cmd", {16'd0, cmd}, 32'h47F3);
    check("t1_rdy", {31'd0, cmd_rdy}, 32'd1);
    n_tests++;
    if (lat < 9 * B + B / 2 + 1 || lat > 9 * B + B / 2 + 4) begin
      n_fail++;
      $display("FAIL t1_latency: got %0d clks, required %0d..%0d", lat, 9 * B + B / 2 + 1, 9 * B + B / 2 + 4);
    end
    clear_rdy();
    check("t1_clr", {31'd0, cmd_rdy}, 32'd0);

    foreach (tbl[i]) begin
      rx_pair(tbl[i].hi, tbl[i].lo, tbl[i].gap);
      idle(1);
      check($sformatf("tbl%0d_rdy", i), {31'd0, cmd_rdy}, 32'd1);
      check($sformatf("tbl%0d_cmd", i), {16'd0, cmd}, {16'd0, tbl[i].exp});
      clear_rdy();
    end
    check("tbl_no_errs", frm_cnt + ovr_cnt, 32'd0);

    // Stale high byte is dropped after the inter-byte timeout.
    send_byte(8'h47, 1'b1);
    idle(25);
    check("t2_no_rdy_gap", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h12, 1'b1);
    idle(1);
    check("t2_no_rdy_hi", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h34, 1'b1);
    idle(1);
    check("t2_cmd", {16'd0, cmd}, 32'h1234);
    check("t2_rdy", {31'd0, cmd_rdy}, 32'd1);
    clear_rdy();

    // Framing error on a high byte leaves the assembler waiting for a fresh high byte.
    frm0 = frm_cnt;
    send_byte(8'h5C, 1'b0);
    idle(2);
    check("t3_frm_pulse", frm_cnt - frm0, 32'd1);
    check("t3_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    rx_pair(8'hA5, 8'h5A, 1);
    idle(1);
    check("t3_cmd", {16'd0, cmd}, 32'hA55A);
    check("t3_rdy", {31'd0, cmd_rdy}, 32'd1);
    clear_rdy();

    // Response frame, mid-frame request ignored, request alongside resp_sent accepted.
    fr = {1'b1, knight_uart_pkg::POS_ACK, 1'b0};
    bad = '0;
    early = 0;
    resp = knight_uart_pkg::POS_ACK;
    send_resp = 1'b1;
    for (int c = 0; c < 10 * B; c++) begin
      @(negedge clk);
      if (c == 0) send_resp = 1'b0;
      if (c == 3 * B) begin
        resp = 8'h0F;
        send_resp = 1'b1;
      end
      if (c == 3 * B + 1) send_resp = 1'b0;
      if (TX !== fr[c / B]) bad[c / B] = 1'b1;
      if (resp_sent) early++;
    end
    for (int b = 0; b < 10; b++) check($sformatf("t4_tx_bit%0d_err", b), {31'd0, bad[b]}, 32'd0);
    check("t4_no_early_sent", early, 32'd0);
    @(negedge clk);
    check("t4_resp_sent", {31'd0, resp_sent}, 32'd1);
    resp = 8'h3C;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    check("t4_sent_single", {31'd0, resp_sent}, 32'd0);
    check("t4_reaccept_start", {31'd0, TX}, 32'd0);
    repeat (10 * B + 2) @(negedge clk);
    check("t4_tx_idle", {31'd0, TX}, 32'd1);

    // Overrun: completion lands in the same clk as clr_cmd_rdy.
    rx_pair(8'h11, 8'h22, 0);
    idle(1);
    check("t5_pre_rdy", {31'd0, cmd_rdy}, 32'd1);
    send_byte(8'h20, 1'b1);
    check("t5_cmd_stable", {16'd0, cmd}, 32'h1122);
    fork
      send_byte(8'h01, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("t5_cmd", {16'd0, cmd}, 32'h2001);
        check("t5_rdy_kept", {31'd0, cmd_rdy}, 32'd1);
        check("t5_ovr_err", {31'd0, ovr_err}, 32'd1);
        @(negedge clk);
        check("t5_ovr_single", {31'd0, ovr_err}, 32'd0);
      end
    join
    idle(1);
    check("t5_rdy_after", {31'd0, cmd_rdy}, 32'd1);
    clear_rdy();

    // Randomized full-duplex traffic against a frame-level model.
    for (int k = 0; k < 6; k++) begin
      logic [7:0] h, l, r;
      int         g;
      h = 8'($urandom);
      l = 8'($urandom);
      r = 8'($urandom);
      g = int'($urandom_range(0, 12));
      exp_q.push_back({h, l});
      fork
        rx_pair(h, l, g);
        tx_send_check(r);
      join
      idle(1);
      check($sformatf("rand%0d_rdy", k), {31'd0, cmd_rdy}, 32'd1);
      check($sformatf("rand%0d_cmd", k), {16'd0, cmd}, {16'd0, exp_q.pop_front()});
      clear_rdy();
    end

    // Reset in the middle of an RX data bit and a TX data bit.
    rx_pair(8'h77, 8'h88, 0);
    idle(1);
    check("t6_pre_rdy", {31'd0, cmd_rdy}, 32'd1);
    fork
      send_byte(8'h55, 1'b1);
      begin
        resp = 8'hC3;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (4 * B) @(negedge clk);
        check("t6_tx_busy_low", {31'd0, TX}, 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_tx", {31'd0, TX}, 32'd1);
        check("t6_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t6_rst_cmd", {16'd0, cmd}, 32'd0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    rx_pair(8'h00, 8'h00, 0);
    idle(1);
    check("t6_cmd", {16'd0, cmd}, 32'h0000);
    check("t6_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("t6_tx_idle", {31'd0, TX}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
